// File: rtl/parity_checker_core.sv
// Receive-side parity checker for a 4-bit nibble plus parity bit.
// Combinational error flag plus a sampled flag, a sticky flag and a saturating error counter.
module parity_checker_core #(
  parameter bit ODD_PARITY = 1'b0,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  input  logic             p,
  input  logic             chk_en,
  input  logic             clr,
  output logic             pec,
  output logic             pec_q,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_cnt
);

  logic             w_x;
  logic             w_pec;
  logic             w_cnt_max;
  logic             w_err_sample;
  logic             r_pec_q;
  logic             r_err_sticky;
  logic [CNT_W-1:0] r_err_cnt;

  assign w_x          = a ^ b ^ c ^ d ^ p;
  assign w_pec        = ODD_PARITY ? ~w_x : w_x;
  assign w_cnt_max    = &r_err_cnt;
  assign w_err_sample = chk_en & w_pec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pec_q      <= 1'b0;
      r_err_sticky <= 1'b0;
      r_err_cnt    <= '0;
    end else begin
      if (chk_en) r_pec_q <= w_pec;
      // clr outranks a simultaneous error: the error is dropped, not counted
      if (clr) begin
        r_err_sticky <= 1'b0;
        r_err_cnt    <= '0;
      end else if (w_err_sample) begin
        r_err_sticky <= 1'b1;
        if (!w_cnt_max) r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  assign pec        = w_pec;
  assign pec_q      = r_pec_q;
  assign err_sticky = r_err_sticky;
  assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_parity_checker_core.sv
// Directed bench for parity_checker_core: even/odd schemes and a narrow counter
// instance share one set of input stimulus.
module tb_parity_checker_core;

  logic clk = 1'b0;
  logic rst_n, a, b, c, d, p, chk_en, clr;

  logic       pec0, pecq0, st0;
  logic [7:0] cnt0;
  logic       pec1, pecq1, st1;
  logic [7:0] cnt1;
  logic       pec2, pecq2, st2;
  logic [3:0] cnt2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  parity_checker_core #(.ODD_PARITY(1'b0), .CNT_W(8)) u_even (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .p(p),
    .chk_en(chk_en), .clr(clr),
    .pec(pec0), .pec_q(pecq0), .err_sticky(st0), .err_cnt(cnt0));

  parity_checker_core #(.ODD_PARITY(1'b1), .CNT_W(8)) u_odd (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .p(p),
    .chk_en(chk_en), .clr(clr),
    .pec(pec1), .pec_q(pecq1), .err_sticky(st1), .err_cnt(cnt1));

  parity_checker_core #(.ODD_PARITY(1'b0), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .p(p),
    .chk_en(chk_en), .clr(clr),
    .pec(pec2), .pec_q(pecq2), .err_sticky(st2), .err_cnt(cnt2));

  typedef struct {
    logic [4:0] v;
    logic       ep_even;
    logic       ep_odd;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic [4:0] v);
    {a, b, c, d, p} = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp8;
  int exp4;
  logic [4:0] v5;

  initial begin
    tbl[0] = '{5'b00000, 1'b0, 1'b1};
    tbl[1] = '{5'b00001, 1'b1, 1'b0};
    tbl[2] = '{5'b10000, 1'b1, 1'b0};
    tbl[3] = '{5'b10001, 1'b0, 1'b1};
    tbl[4] = '{5'b11110, 1'b0, 1'b1};
    tbl[5] = '{5'b11111, 1'b1, 1'b0};
    tbl[6] = '{5'b01010, 1'b0, 1'b1};
    tbl[7] = '{5'b00111, 1'b1, 1'b0};

    rst_n = 1'b0; chk_en = 1'b0; clr = 1'b0;
    set_in(5'b0);

    // Reset held: registers stay zero while errors are strobed, pec still live
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      v5 = 5'(i * 7 + 1);
      set_in(v5);
      chk_en = 1'b1;
      tick();
      check("rst_pec",   32'(pec0), 32'(^v5));
      check("rst_regs",  {29'd0, pecq0, st0, (cnt0 != 0)}, 32'd0);
      check("rst_regs4", {29'd0, pecq2, st2, (cnt2 != 0)}, 32'd0);
    end
    chk_en = 1'b0;

    for (int i = 0; i < 8; i++) begin
      set_in(tbl[i].v);
      #1;
      check("tbl_even", 32'(pec0), 32'(tbl[i].ep_even));
      check("tbl_odd",  32'(pec1), 32'(tbl[i].ep_odd));
    end

    for (int i = 0; i < 32; i++) begin
      v5 = 5'(i);
      set_in(v5);
      #1;
      check("sweep_even", 32'(pec0), 32'(($countones(v5) % 2) == 1));
      check("sweep_odd",  32'(pec1), 32'(($countones(v5) % 2) == 0));
    end

    @(negedge clk);
    rst_n = 1'b1;

    // Counting over all 32 patterns
    exp8 = 0; exp4 = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      v5 = 5'(i);
      set_in(v5);
      chk_en = 1'b1;
      tick();
      if (($countones(v5) % 2) == 1) begin
        exp8++;
        if (exp4 < 15) exp4++;
      end
      check("cnt_pecq",  32'(pecq0), 32'(($countones(v5) % 2) == 1));
      check("cnt_even",  32'(cnt0), 32'(exp8));
      check("cnt_sat4",  32'(cnt2), 32'(exp4));
    end
    @(negedge clk);
    chk_en = 1'b0;
    check("cnt_total",  32'(cnt0), 32'd16);
    check("cnt_sticky", 32'(st0), 32'd1);
    check("cnt_w4",     32'(cnt2), 32'd15);

    // Plain clear: pec_q keeps last captured value (11111 -> 1)
    clr = 1'b1;
    tick();
    @(negedge clk);
    clr = 1'b0;
    check("clr_cnt",    32'(cnt0), 32'd0);
    check("clr_sticky", 32'(st0), 32'd0);
    check("clr_pecq",   32'(pecq0), 32'd1);

    // Saturation on the 4-bit counter
    set_in(5'b00010);
    chk_en = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check("sat_cnt4", 32'(cnt2), 32'((k < 15) ? k : 15));
      @(negedge clk);
    end
    chk_en = 1'b0;
    tick();
    check("sat_hold4", 32'(cnt2), 32'd15);
    check("nochk_cnt", 32'(cnt0), 32'd20);

    // Clear priority over a simultaneous error
    @(negedge clk);
    clr = 1'b1;
    tick();
    @(negedge clk);
    clr = 1'b0;
    set_in(5'b00000);
    chk_en = 1'b1;
    tick();
    check("good_pecq", 32'(pecq0), 32'd0);
    @(negedge clk);
    set_in(5'b00010);
    for (int k = 0; k < 5; k++) begin
      tick();
      @(negedge clk);
    end
    check("pre_clr_cnt", 32'(cnt0), 32'd5);
    clr = 1'b1;
    tick();
    check("prio_cnt",    32'(cnt0), 32'd0);
    check("prio_sticky", 32'(st0), 32'd0);
    check("prio_pecq",   32'(pecq0), 32'd1);
    @(negedge clk);
    clr = 1'b0;
    chk_en = 1'b0;
    set_in(5'b00000);
    tick();
    check("hold_pecq", 32'(pecq0), 32'd1);

    // Build state up again, then async reset between edges
    @(negedge clk);
    set_in(5'b10000);
    chk_en = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk_en = 1'b0;
    check("pre_rst_cnt", 32'(cnt0), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_pecq",   32'(pecq0), 32'd0);
    check("arst_sticky", 32'(st0), 32'd0);
    check("arst_cnt",    32'(cnt0), 32'd0);
    check("arst_cnt4",   32'(cnt2), 32'd0);
    check("arst_pec",    32'(pec0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/parity_checker_core.md
Name: parity_checker_core

Overview:
- Single-word parity checker for a 4-bit data nibble {a,b,c,d} plus one parity bit p.
- Flags a parity error combinationally on `pec`, with no clock dependency. This is the core checking function.
- Adds a clocked sampling stage: registered error flag, sticky error flag and saturating error counter.
- Sits at the receive side of a nibble link, between the incoming data/parity wires and status/interrupt logic.

Parameters:
- ODD_PARITY, 0, 0 = even-parity scheme (total count of ones over a,b,c,d,p must be even); 1 = odd-parity scheme.
- CNT_W, 8, width of the error counter err_cnt (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock for all registers
- rst_n  input  1  asynchronous active-low reset
- a  input  1  data bit 3 (MSB)
- b  input  1  data bit 2
- c  input  1  data bit 1
- d  input  1  data bit 0 (LSB)
- p  input  1  received parity bit
- chk_en  input  1  sample-and-check strobe, one word per cycle while high
- clr  input  1  synchronous clear of the sticky flag and the counter
- pec  output  1  combinational parity error check, 1 = error
- pec_q  output  1  registered pec, captured on chk_en
- err_sticky  output  1  set on any sampled error, held until clr or reset
- err_cnt  output  CNT_W  count of sampled errors, saturating

Behaviour:
- Parity function:
  - x = a^b^c^d^p.
  - pec = x when ODD_PARITY=0; pec = ~x when ODD_PARITY=1.
  - Purely combinational, zero latency, independent of clk, rst_n, chk_en and clr. It follows input changes within the same delta/time step.
- Reset (rst_n=0, asynchronous assert): pec_q=0, err_sticky=0, err_cnt=0 immediately.
  - Deassertion is synchronised by the integrator.
  - The first capture happens on the first rising clk edge after deassertion with chk_en=1.
  - Reset mid-operation discards all history.
- On rising clk edge, when rst_n=1:
  - pec_q: when chk_en=1, pec_q <= pec. Otherwise pec_q holds. pec_q is not affected by clr.
  - err_sticky:
    - when clr=1, err_sticky <= 0;
    - else when chk_en=1 and pec=1, err_sticky <= 1;
    - else it holds.
  - err_cnt:
    - when clr=1, err_cnt <= 0;
    - else when chk_en=1, pec=1 and err_cnt != 2^CNT_W-1, err_cnt <= err_cnt+1;
    - else it holds. The counter saturates at all-ones and never wraps.
- Simultaneous clr=1 and chk_en=1 with an error: clr has priority. err_cnt=0 and err_sticky=0 after the edge, the error is not counted, and pec_q still captures 1.
- Latency:
  - pec: 0 cycles.
  - pec_q, err_sticky, err_cnt: 1 cycle after the sampling edge.
- X-handling: no requirement beyond standard RTL semantics. Inputs are assumed stable around the clk edge when chk_en=1.
- No internal state other than pec_q, err_sticky and err_cnt.

Test Plan:
- Reset: hold rst_n=0, toggle inputs and clk -> pec_q=0, err_sticky=0, err_cnt=0 throughout; pec still tracks inputs.
- Exhaustive combinational sweep, ODD_PARITY=0, {a,b,c,d,p} counting 0..31 at 1 ns steps -> pec=1 exactly when popcount is odd.
  - 00000 -> 0; 00001 -> 1; 10000 -> 1; 10001 -> 0; 11110 -> 0; 11111 -> 1.
- Same sweep with ODD_PARITY=1 -> every pec value inverted (00000 -> 1, 00001 -> 0).
- Counting, ODD_PARITY=0: 32 consecutive cycles with chk_en=1 over all 32 patterns -> err_cnt=16, err_sticky=1; pec_q equals pec of the previous cycle's pattern.
- Saturation, CNT_W=4: 20 sampled erroring words (abcd=0001, p=0) -> err_cnt stops at 15 and stays 15.
- Clear priority and async reset:
  - err_cnt=5, then clr=1 together with chk_en=1 on an error word -> err_cnt=0, err_sticky=0, pec_q=1.
  - Then drop rst_n between clock edges -> all registered outputs 0 immediately, without waiting for a clock edge.
